// File: rtl/bram_dp_be_pkg.sv
// ---------------------------------------------------------------------------
// bram_dp_be_pkg
// Shared definitions for the dual-port byte-enable scratchpad RAM.
//   READ_FIRST / WRITE_FIRST : same-port read-during-write selection values
//   state_e                  : init FSM states (CLEAR sweep, RUN service)
//   BE_W                     : byte-lane count of the default 128-bit word
//   be_count()               : byte-lane count for an arbitrary data width
// ---------------------------------------------------------------------------
package bram_dp_be_pkg;

  // Same-port read-during-write behaviour.
  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  // Init FSM: CLEAR zeroes the array word by word, RUN serves both ports.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Byte-lane count for the default word width used by the GEMM scratchpads.
  localparam int DEFAULT_WIDTH = 128;
  localparam int BE_W          = DEFAULT_WIDTH / 8;

  // Byte-lane count for any parameterised width (width is a multiple of 8).
  function automatic int be_count(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/bram_dp_be_out_pipe.sv
// ---------------------------------------------------------------------------
// bram_out_pipe
// Output data/valid register stage(s) for one RAM port.
//   clk       : clock
//   rst       : asynchronous active-low reset, clears data and valid
//   in_valid  : an access was accepted this cycle
//   in_data   : read word belonging to that access
//   out_valid : one-cycle pulse, LATENCY cycles after the access
//   out_data  : read word; holds its last value between accesses
// LATENCY = 2 adds a second register that loads only when stage one holds a
// valid result, so both stages keep their data while the port is idle.
// Any LATENCY other than 2 behaves as a single stage.
// ---------------------------------------------------------------------------
module bram_out_pipe #(
  parameter int WIDTH   = 128,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;

  // Stage one captures the read word only on an accepted access.
  always_comb begin
    s1_valid_d = in_valid;
    s1_data_d  = s1_data_q;
    if (in_valid) begin
      s1_data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  generate
    if (LATENCY == 2) begin : g_two_stage
      logic             s2_valid_q, s2_valid_d;
      logic [WIDTH-1:0] s2_data_q,  s2_data_d;

      // Second stage advances only behind a valid first-stage result.
      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        if (s1_valid_q) begin
          s2_data_d = s1_data_q;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign out_valid = s2_valid_q;
      assign out_data  = s2_data_q;
    end else begin : g_one_stage
      assign out_valid = s1_valid_q;
      assign out_data  = s1_data_q;
    end
  endgenerate

endmodule

// File: rtl/bram_dp_be.sv
// ---------------------------------------------------------------------------
// bram_dp_be
// True dual-port block RAM with per-byte write enables for the GEMM core's
// input, weight and accumulator scratchpads. Both ports share one clock.
//   clk                      : clock for both ports
//   rst                      : asynchronous active-low reset
//   init_busy                : high while the clear sweep zeroes the array;
//                              port requests are ignored meanwhile
//   ena / enb                : port access request
//   wea / web                : byte write enables (all zero = read)
//   addra / addrb            : word address
//   dina / dinb              : write data
//   douta / doutb            : read data, held between accesses
//   douta_valid/doutb_valid  : one-cycle pulse with each new dout
//   collision                : pulse when both ports write a common byte of
//                              one address; aligned with douta_valid
// Parameters: WIDTH (multiple of 8), DEPTH, ADDR, LATENCY (1 or 2),
// RDW_MODE (READ_FIRST / WRITE_FIRST), FILE (non-empty = array contents are
// supplied at configuration time, so the clear sweep is skipped).
// ---------------------------------------------------------------------------
module bram_dp_be
  import bram_dp_be_pkg::*;
#(
  parameter int    WIDTH    = 128,
  parameter int    DEPTH    = 1024,
  parameter int    ADDR     = 10,
  parameter int    LATENCY  = 1,
  parameter int    RDW_MODE = READ_FIRST,
  parameter string FILE     = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  ena,
  input  logic [WIDTH/8-1:0]    wea,
  input  logic [ADDR-1:0]       addra,
  input  logic [WIDTH-1:0]      dina,
  output logic [WIDTH-1:0]      douta,
  output logic                  douta_valid,
  input  logic                  enb,
  input  logic [WIDTH/8-1:0]    web,
  input  logic [ADDR-1:0]       addrb,
  input  logic [WIDTH-1:0]      dinb,
  output logic [WIDTH-1:0]      doutb,
  output logic                  doutb_valid,
  output logic                  collision
);

  localparam int NB    = be_count(WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit SWEEP = (FILE == "");

  // -------------------------------------------------------------------------
  // Init FSM: state register / next-state / outputs
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             init_busy_q, init_busy_d;
  logic             sweep_we;
  logic             sweep_last;

  assign sweep_last = (cnt_q == IDX_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SWEEP ? CLEAR : RUN;
      cnt_q       <= '0;
      init_busy_q <= SWEEP;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (sweep_last) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // init_busy falls on the same edge that writes the last word, so the
  // first request that can be accepted is sampled with init_busy already 0.
  always_comb begin
    sweep_we    = (state_q == CLEAR) && rst;
    cnt_d       = cnt_q;
    init_busy_d = (state_d == CLEAR);
    if (state_q == CLEAR) begin
      cnt_d = sweep_last ? '0 : cnt_q + 1'b1;
    end
  end

  assign init_busy = init_busy_q;

  // -------------------------------------------------------------------------
  // Port request decode
  // -------------------------------------------------------------------------
  logic             run;
  logic             acc_a, acc_b;
  logic             in_range_a, in_range_b;
  logic             wr_a, wr_b;
  logic [IDX_W-1:0] idx_a, idx_b;

  // rst is folded in so a preloaded array is never written while in reset.
  assign run        = (state_q == RUN) && rst;
  assign acc_a      = ena && run;
  assign acc_b      = enb && run;
  assign in_range_a = (32'(addra) < 32'(DEPTH));
  assign in_range_b = (32'(addrb) < 32'(DEPTH));
  assign wr_a       = acc_a && in_range_a && (|wea);
  assign wr_b       = acc_b && in_range_b && (|web);
  assign idx_a      = addra[IDX_W-1:0];
  assign idx_b      = addrb[IDX_W-1:0];

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  // Port B lanes are written first so port A wins any byte both ports
  // enable at the same address; disjoint lanes from both ports land.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt_q] <= '0;
    end
    for (int k = 0; k < NB; k++) begin
      if (wr_b && web[k]) begin
        mem[idx_b][k*8 +: 8] <= dinb[k*8 +: 8];
      end
      if (wr_a && wea[k]) begin
        mem[idx_a][k*8 +: 8] <= dina[k*8 +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path: the array is sampled before this edge's writes land, which
  // gives the old word for READ_FIRST and for any cross-port read.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] old_a, old_b;
  logic [WIDTH-1:0] merged_a, merged_b;
  logic [WIDTH-1:0] rdata_a, rdata_b;

  assign old_a = in_range_a ? mem[idx_a] : '0;
  assign old_b = in_range_b ? mem[idx_b] : '0;

  // WRITE_FIRST view: the port's own written lanes over the old word.
  generate
    for (genvar k = 0; k < NB; k++) begin : g_merge
      assign merged_a[k*8 +: 8] = wea[k] ? dina[k*8 +: 8] : old_a[k*8 +: 8];
      assign merged_b[k*8 +: 8] = web[k] ? dinb[k*8 +: 8] : old_b[k*8 +: 8];
    end
  endgenerate

  // Out-of-range accesses always read back zero, whatever the RDW mode.
  assign rdata_a = ((RDW_MODE == WRITE_FIRST) && in_range_a) ? merged_a : old_a;
  assign rdata_b = ((RDW_MODE == WRITE_FIRST) && in_range_b) ? merged_b : old_b;

  // -------------------------------------------------------------------------
  // Collision detect, delayed to line up with douta_valid
  // -------------------------------------------------------------------------
  logic coll_now;
  logic coll1_q, coll1_d;
  logic coll2_q, coll2_d;

  assign coll_now = wr_a && wr_b && (idx_a == idx_b) && (|(wea & web));

  always_comb begin
    coll1_d = coll_now;
    coll2_d = coll1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coll1_q <= 1'b0;
      coll2_q <= 1'b0;
    end else begin
      coll1_q <= coll1_d;
      coll2_q <= coll2_d;
    end
  end

  assign collision = (LATENCY == 2) ? coll2_q : coll1_q;

  // -------------------------------------------------------------------------
  // Output pipelines, one per port
  // -------------------------------------------------------------------------
  bram_out_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc_a),
    .in_data   (rdata_a),
    .out_valid (douta_valid),
    .out_data  (douta)
  );

  bram_out_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc_b),
    .in_data   (rdata_b),
    .out_valid (doutb_valid),
    .out_data  (doutb)
  );

endmodule

// File: tb/tb_bram_dp_be.sv
// ---------------------------------------------------------------------------
// tb_bram_dp_be
// Drives two instances side by side from the same stimulus:
//   dut1 : LATENCY=1, READ_FIRST
//   dut2 : LATENCY=2, WRITE_FIRST
// Every accepted request pushes the hand-computed response for each instance
// into a per-port queue; a monitor on the falling edge pops and compares
// whenever a valid appears, including the read latency and collision flag.
// ---------------------------------------------------------------------------
module tb_bram_dp_be;

  localparam int W  = 128;
  localparam int NB = W / 8;
  localparam int D  = 16;
  localparam int AW = 5;

  localparam logic [W-1:0] W55   = {16{8'h55}};
  localparam logic [W-1:0] WFF   = {16{8'hFF}};
  localparam logic [W-1:0] WFF00 = {{15{8'hFF}}, 8'h00};
  localparam logic [W-1:0] W11   = 128'h11;
  localparam logic [W-1:0] W22   = 128'h22;
  localparam logic [W-1:0] WAA   = {16{8'hAA}};
  localparam logic [W-1:0] WBB   = {16{8'hBB}};
  localparam logic [W-1:0] W12   = {16{8'h12}};
  localparam logic [W-1:0] W34   = {16{8'h34}};
  localparam logic [W-1:0] ZERO  = '0;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  cyc;
    logic         coll;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          ena = 1'b0, enb = 1'b0;
  logic [NB-1:0] wea = '0,   web = '0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [W-1:0]  dina = '0,  dinb = '0;

  logic          init_busy1, init_busy2;
  logic [W-1:0]  douta1, doutb1, douta2, doutb2;
  logic          douta_valid1, doutb_valid1, douta_valid2, doutb_valid2;
  logic          collision1, collision2;

  int          tests    = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  exp_t  q [4][$];
  exp_t  mon_e;
  string pname [4] = '{"A1", "B1", "A2", "B2"};
  int    lat   [4] = '{1, 1, 2, 2};
  logic         vld [4];
  logic [W-1:0] dat [4];
  logic         coll [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bram_dp_be #(
    .WIDTH(W), .DEPTH(D), .ADDR(AW), .LATENCY(1),
    .RDW_MODE(bram_dp_be_pkg::READ_FIRST), .FILE("")
  ) dut1 (
    .clk(clk), .rst(rst), .init_busy(init_busy1),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta1), .douta_valid(douta_valid1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(doutb1), .doutb_valid(doutb_valid1),
    .collision(collision1)
  );

  bram_dp_be #(
    .WIDTH(W), .DEPTH(D), .ADDR(AW), .LATENCY(2),
    .RDW_MODE(bram_dp_be_pkg::WRITE_FIRST), .FILE("")
  ) dut2 (
    .clk(clk), .rst(rst), .init_busy(init_busy2),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta2), .douta_valid(douta_valid2),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(doutb2), .doutb_valid(doutb_valid2),
    .collision(collision2)
  );

  always_comb begin
    vld[0] = douta_valid1; dat[0] = douta1;
    vld[1] = doutb_valid1; dat[1] = doutb1;
    vld[2] = douta_valid2; dat[2] = douta2;
    vld[3] = doutb_valid2; dat[3] = doutb2;
    coll[0] = collision1;
    coll[1] = collision2;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of port requests at a falling edge and queues the
  // expected response of each instance (rf = dut1, wf = dut2).
  task automatic applyStimulus(
    input logic ea, input logic [NB-1:0] wa, input logic [AW-1:0] aa,
    input logic [W-1:0] da,
    input logic eb, input logic [NB-1:0] wb, input logic [AW-1:0] ab,
    input logic [W-1:0] db,
    input logic [W-1:0] exp_a_rf, input logic [W-1:0] exp_a_wf,
    input logic [W-1:0] exp_b_rf, input logic [W-1:0] exp_b_wf,
    input logic exp_coll);
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    if (ea) begin
      q[0].push_back('{exp_a_rf, cyc, exp_coll});
      q[2].push_back('{exp_a_wf, cyc, exp_coll});
    end
    if (eb) begin
      q[1].push_back('{exp_b_rf, cyc, 1'b0});
      q[3].push_back('{exp_b_wf, cyc, 1'b0});
    end
    @(negedge clk);
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
  endtask

  task automatic rdA(input logic [AW-1:0] a, input logic [W-1:0] e);
    applyStimulus(1'b1, '0, a, ZERO, 1'b0, '0, '0, ZERO, e, e, ZERO, ZERO, 1'b0);
  endtask

  task automatic wrA(input logic [AW-1:0] a, input logic [NB-1:0] we,
                     input logic [W-1:0] d, input logic [W-1:0] e_rf,
                     input logic [W-1:0] e_wf);
    applyStimulus(1'b1, we, a, d, 1'b0, '0, '0, ZERO, e_rf, e_wf, ZERO, ZERO, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts falling-edge samples with init_busy high, starting at the
  // release edge, and pokes port A mid-sweep (which must be ignored).
  task automatic waitSweep();
    int n1;
    int n2;
    int guard;
    n1 = 0; n2 = 0; guard = 0;
    while ((init_busy1 || init_busy2) && guard < 100) begin
      if (init_busy1) n1++;
      if (init_busy2) n2++;
      guard++;
      ena = (guard == 5); wea = '1; addra = 5'd3; dina = WFF;
      @(negedge clk);
    end
    ena = 1'b0; wea = '0; dina = '0;
    checkOutput("sweep busy cycles dut1", W'(n1), W'(D));
    checkOutput("sweep busy cycles dut2", W'(n2), W'(D));
  endtask

  // Monitor: pops the scoreboard whenever an instance presents a result.
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (vld[p]) begin
        if (q[p].size() == 0) begin
          tests++;
          failures++;
          $display("[TB] FAIL %s unexpected valid: got 1 required 0", pname[p]);
        end else begin
          mon_e = q[p].pop_front();
          checkOutput({pname[p], " dout"}, dat[p], mon_e.data);
          checkOutput({pname[p], " latency"}, W'(cyc - mon_e.cyc), W'(lat[p]));
          if (p % 2 == 0) begin
            checkOutput({pname[p], " collision"}, W'(coll[p/2]), W'(mon_e.coll));
          end
        end
      end else if ((p % 2 == 0) && coll[p/2]) begin
        tests++;
        failures++;
        $display("[TB] FAIL %s stray collision: got 1 required 0", pname[p]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    #1 rst = 1'b0;
    #1;
    checkOutput("reset douta1", douta1, ZERO);
    checkOutput("reset douta2", douta2, ZERO);
    checkOutput("reset valids", W'({douta_valid1, doutb_valid1, douta_valid2, doutb_valid2}), ZERO);
    checkOutput("reset collision", W'({collision1, collision2}), ZERO);
    checkOutput("reset init_busy", W'({init_busy1, init_busy2}), W'(2'b11));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    waitSweep();

    // Every word reads zero after the sweep; B walks downwards alongside A.
    for (int i = 0; i < D; i++) begin
      applyStimulus(1'b1, '0, AW'(i), ZERO, 1'b1, '0, AW'(D - 1 - i), ZERO,
                    ZERO, ZERO, ZERO, ZERO, 1'b0);
    end

    // Write then back-to-back reads
    wrA(5'd3, '1, W55, ZERO, W55);
    rdA(5'd3, W55);
    rdA(5'd3, W55);

    // Single byte lane write over an all-ones word
    wrA(5'd4, '1, WFF, ZERO, WFF);
    wrA(5'd4, 16'h0001, ZERO, WFF, WFF00);
    rdA(5'd4, WFF00);

    // Read-during-write: A writes 0x22 over 0x11 while B reads the word
    wrA(5'd5, '1, W11, ZERO, W11);
    applyStimulus(1'b1, '1, 5'd5, W22, 1'b1, '0, 5'd5, ZERO,
                  W11, W22, W11, W11, 1'b0);
    rdA(5'd5, W22);

    // Overlapping dual write: A wins, collision pulses once
    applyStimulus(1'b1, '1, 5'd7, WAA, 1'b1, '1, 5'd7, WBB,
                  ZERO, WAA, ZERO, WBB, 1'b1);
    rdA(5'd7, WAA);

    // Disjoint dual write: lanes merge, no collision
    applyStimulus(1'b1, 16'h0001, 5'd8, W12, 1'b1, 16'h0002, 5'd8, W34,
                  ZERO, 128'h12, ZERO, 128'h3400, 1'b0);
    rdA(5'd8, 128'h3412);

    // Out-of-range: write dropped (no alias onto word 4), read gives zero
    wrA(5'd20, '1, WFF, ZERO, ZERO);
    rdA(5'd20, ZERO);
    rdA(5'd4, WFF00);
    idle(4);

    // Reset in the middle of a read in flight
    ena = 1'b1; wea = '0; addra = 5'd3;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    ena = 1'b0;
    checkOutput("midreset douta1", douta1, ZERO);
    checkOutput("midreset douta2", douta2, ZERO);
    checkOutput("midreset valids", W'({douta_valid1, douta_valid2}), ZERO);
    checkOutput("midreset init_busy", W'({init_busy1, init_busy2}), W'(2'b11));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    waitSweep();
    rdA(5'd3, ZERO);
    rdA(5'd15, ZERO);
    idle(4);

    checkOutput("scoreboard drained",
                W'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), ZERO);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
